pol_glb_rd_arb: RTL and testbench

//   Shares one GLB read port among POOL_CORE pooling cores. A round-robin arbiter

---
 rtl/pol_glb_rd_arb_if.sv | 33 +++
 rtl/pol_glb_rd_arb.sv | 117 +++++++++++
 tb/tb_pol_glb_rd_arb.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pol_glb_rd_arb_if.sv
// Bundle of the core-side request/response channels and the GLB read channels
// shared by the pooling cores and the read arbiter.
interface pol_glb_rd_arb_if #(
  parameter int POOL_CORE  = 6,
  parameter int IDX_WIDTH  = 10,
  parameter int DATA_WIDTH = 512
);
  // Handshake rule for every channel: a transfer happens in a cycle where valid
  // and ready are both high; a valid that is raised stays up with stable payload
  // until it is accepted, and ready may depend combinationally on valid.
  logic [POOL_CORE-1:0]           req_vld;
  logic [IDX_WIDTH*POOL_CORE-1:0] req_addr;
  logic [POOL_CORE-1:0]           req_rdy;
  logic                           glb_addr_vld;
  logic [IDX_WIDTH-1:0]           glb_addr;
  logic                           glb_addr_rdy;
  logic [DATA_WIDTH-1:0]          glb_dat;
  logic                           glb_dat_vld;
  logic                           glb_dat_rdy;
  logic [DATA_WIDTH-1:0]          rsp_dat;
  logic [POOL_CORE-1:0]           rsp_vld;
  logic [POOL_CORE-1:0]           rsp_rdy;

  modport slave (
    input  req_vld, req_addr, glb_addr_rdy, glb_dat, glb_dat_vld, rsp_rdy,
    output req_rdy, glb_addr_vld, glb_addr, glb_dat_rdy, rsp_dat, rsp_vld
  );

  modport master (
    output req_vld, req_addr, glb_addr_rdy, glb_dat, glb_dat_vld, rsp_rdy,
    input  req_rdy, glb_addr_vld, glb_addr, glb_dat_rdy, rsp_dat, rsp_vld
  );
endinterface

// File: rtl/pol_glb_rd_arb.sv
// Round-robin arbiter sharing one GLB read port among POOL_CORE pooling cores, with an
// in-order tag FIFO routing read data back. Optional stall counter: POL_RD_ARB_PERF_EN.
module pol_glb_rd_arb #(
  parameter int POOL_CORE  = 6,
  parameter int IDX_WIDTH  = 10,
  parameter int DATA_WIDTH = 512,
  parameter int MAX_OUTSTD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  pol_glb_rd_arb_if.slave bus,
  output logic busy,
  output logic err
`ifdef POL_RD_ARB_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int PW = (POOL_CORE > 1) ? $clog2(POOL_CORE) : 1;
  localparam int AW = (MAX_OUTSTD > 1) ? $clog2(MAX_OUTSTD) : 1;
  localparam int CW = AW + 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] tag_mem [MAX_OUTSTD];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic [PW-1:0] gnt;
  logic [PW-1:0] head;
  logic          any_req;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          found;
  int            idx;

  assign any_req = |bus.req_vld;
  assign full    = (cnt == CW'(MAX_OUTSTD));
  assign empty   = (cnt == '0);
  assign head    = tag_mem[rd_ptr];

  // Search upward from rr_ptr with wrap; gnt depends only on req_vld and rr_ptr,
  // so a stalled grant stays put while its request is held.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < POOL_CORE; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= POOL_CORE) idx = idx - POOL_CORE;
      if (!found && bus.req_vld[idx]) begin
        gnt   = idx[PW-1:0];
        found = 1'b1;
      end
    end
  end

  assign bus.glb_addr_vld = any_req & ~full;
  assign bus.glb_addr     = bus.req_addr[int'(gnt)*IDX_WIDTH +: IDX_WIDTH];

  always_comb begin
    bus.req_rdy = '0;
    if (any_req && bus.glb_addr_rdy && !full) bus.req_rdy[gnt] = 1'b1;
  end

  always_comb begin
    bus.rsp_vld = '0;
    if (bus.glb_dat_vld && !empty) bus.rsp_vld[head] = 1'b1;
  end

  assign bus.glb_dat_rdy = ~empty & bus.rsp_rdy[head];
  assign bus.rsp_dat     = bus.glb_dat;

  assign push = bus.glb_addr_vld & bus.glb_addr_rdy;
  assign pop  = bus.glb_dat_vld & bus.glb_dat_rdy;
  assign busy = ~empty | any_req;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTD; i++) tag_mem[i] <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= gnt;
        wr_ptr          <= wr_ptr + 1'b1;
        rr_ptr          <= (gnt == PW'(POOL_CORE - 1)) ? '0 : gnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // Data with nothing outstanding means the GLB and the tag FIFO disagree.
      if (bus.glb_dat_vld && empty) err <= 1'b1;
    end
  end

`ifdef POL_RD_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      perf_stall_cnt <= '0;
    end else if (any_req && !push && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pol_glb_rd_arb.sv
// Directed self-checking bench for pol_glb_rd_arb: round-robin order, skip pattern,
// full FIFO back-pressure, in-order response routing, stall, err and clr.
module tb_pol_glb_rd_arb;
  localparam int PC = 6;
  localparam int IW = 10;
  localparam int DW = 512;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic busy;
  logic err;
`ifdef POL_RD_ARB_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] d0;
  logic [DW-1:0] d1;

  pol_glb_rd_arb_if #(.POOL_CORE(PC), .IDX_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  pol_glb_rd_arb #(.POOL_CORE(PC), .IDX_WIDTH(IW), .DATA_WIDTH(DW), .MAX_OUTSTD(MO)) dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .bus  (bus),
    .busy (busy),
    .err  (err)
`ifdef POL_RD_ARB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_vld      = '0;
    bus.glb_addr_rdy = 1'b0;
    bus.glb_dat      = '0;
    bus.glb_dat_vld  = 1'b0;
    bus.rsp_rdy      = '0;
    for (int i = 0; i < PC; i++) bus.req_addr[i*IW +: IW] = IW'(10'h100 + i);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.glb_addr_vld !== 1'b0) begin n_errors++; $display("FAIL rst_addr_vld got %b exp 0", bus.glb_addr_vld); end
    n_checks++; if (bus.req_rdy !== 6'b0) begin n_errors++; $display("FAIL rst_req_rdy got %b exp 0", bus.req_rdy); end
    rst = 1'b0;
    tick();
    n_checks++; if (bus.rsp_vld !== 6'b0) begin n_errors++; $display("FAIL rst_rsp_vld got %b exp 0", bus.rsp_vld); end
    n_checks++; if (bus.glb_dat_rdy !== 1'b0) begin n_errors++; $display("FAIL rst_dat_rdy got %b exp 0", bus.glb_dat_rdy); end
    n_checks++; if ({busy, err} !== 2'b00) begin n_errors++; $display("FAIL rst_busy_err got %b exp 00", {busy, err}); end
  endtask

  // All cores requesting, one read outstanding at a time: grants 0..5 then 0.
  task automatic test_rr_all();
    logic [5:0] exp_g;
    logic [5:0] exp_r;
    bus.req_vld      = 6'b111111;
    bus.glb_addr_rdy = 1'b1;
    bus.rsp_rdy      = 6'b111111;
    for (int c = 0; c < 7; c++) begin
      bus.glb_dat_vld = (c > 0);
      exp_g = 6'b1 << (c % 6);
      exp_r = (c > 0) ? (6'b1 << ((c - 1) % 6)) : 6'b0;
      #1;
      n_checks++; if (bus.req_rdy !== exp_g) begin n_errors++; $display("FAIL rr_all_gnt c=%0d got %b exp %b", c, bus.req_rdy, exp_g); end
      n_checks++; if (bus.glb_addr !== IW'(10'h100 + (c % 6))) begin n_errors++; $display("FAIL rr_all_addr c=%0d got %h exp %h", c, bus.glb_addr, 10'h100 + (c % 6)); end
      n_checks++; if (bus.rsp_vld !== exp_r) begin n_errors++; $display("FAIL rr_all_rsp c=%0d got %b exp %b", c, bus.rsp_vld, exp_r); end
      tick();
    end
    bus.req_vld = '0;
    bus.glb_dat_vld = 1'b1;
    #1;
    n_checks++; if (bus.rsp_vld !== 6'b000001) begin n_errors++; $display("FAIL rr_all_last_rsp got %b exp 000001", bus.rsp_vld); end
    tick();
    bus.glb_dat_vld = 1'b0;
    #1;
    n_checks++; if ({busy, err} !== 2'b00) begin n_errors++; $display("FAIL rr_all_idle got %b exp 00", {busy, err}); end
  endtask

  // req_vld=100100 with rr_ptr=3 -> core 5, then wrap to 0 -> core 2.
  task automatic test_rr_skip();
    do_clr();
    bus.glb_addr_rdy = 1'b1;
    bus.rsp_rdy      = 6'b111111;
    bus.req_vld      = 6'b000100;
    #1;
    n_checks++; if (bus.req_rdy !== 6'b000100) begin n_errors++; $display("FAIL skip_pre got %b exp 000100", bus.req_rdy); end
    tick();
    bus.req_vld = 6'b100100;
    bus.glb_dat_vld = 1'b1;
    #1;
    n_checks++; if (bus.req_rdy !== 6'b100000) begin n_errors++; $display("FAIL skip_gnt5 got %b exp 100000", bus.req_rdy); end
    n_checks++; if (bus.glb_addr !== 10'h105) begin n_errors++; $display("FAIL skip_addr5 got %h exp 105", bus.glb_addr); end
    n_checks++; if (bus.rsp_vld !== 6'b000100) begin n_errors++; $display("FAIL skip_rsp2 got %b exp 000100", bus.rsp_vld); end
    tick();
    #1;
    n_checks++; if (bus.req_rdy !== 6'b000100) begin n_errors++; $display("FAIL skip_gnt2 got %b exp 000100", bus.req_rdy); end
    n_checks++; if (bus.rsp_vld !== 6'b100000) begin n_errors++; $display("FAIL skip_rsp5 got %b exp 100000", bus.rsp_vld); end
    tick();
    bus.req_vld = '0;
    #1;
    n_checks++; if (bus.rsp_vld !== 6'b000100) begin n_errors++; $display("FAIL skip_rsp2b got %b exp 000100", bus.rsp_vld); end
    tick();
    bus.glb_dat_vld = 1'b0;
  endtask

  // Four pushes fill the FIFO; then a pop while full must not push in the same cycle.
  task automatic test_full();
    do_clr();
    bus.glb_addr_rdy = 1'b1;
    bus.rsp_rdy      = 6'b111111;
    bus.glb_dat_vld  = 1'b0;
    bus.req_vld      = 6'b111111;
    for (int c = 0; c < MO; c++) begin
      #1;
      n_checks++; if (bus.req_rdy !== (6'b1 << c)) begin n_errors++; $display("FAIL full_push c=%0d got %b exp %b", c, bus.req_rdy, 6'b1 << c); end
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if ({bus.glb_addr_vld, bus.req_rdy} !== 7'b0) begin n_errors++; $display("FAIL full_block c=%0d got %b exp 0", c, {bus.glb_addr_vld, bus.req_rdy}); end
      tick();
    end
    bus.glb_dat_vld = 1'b1;
    #1;
    n_checks++; if ({bus.glb_dat_rdy, bus.rsp_vld} !== 7'b1_000001) begin n_errors++; $display("FAIL full_pop got %b exp 1000001", {bus.glb_dat_rdy, bus.rsp_vld}); end
    n_checks++; if ({bus.glb_addr_vld, bus.req_rdy} !== 7'b0) begin n_errors++; $display("FAIL full_nobypass got %b exp 0", {bus.glb_addr_vld, bus.req_rdy}); end
    tick();
    bus.glb_dat_vld = 1'b0;
    #1;
    n_checks++; if (bus.req_rdy !== 6'b010000) begin n_errors++; $display("FAIL full_push_next got %b exp 010000", bus.req_rdy); end
    tick();
    bus.req_vld = '0;
    bus.glb_dat_vld = 1'b1;
    for (int c = 1; c <= MO; c++) begin
      #1;
      n_checks++; if (bus.rsp_vld !== (6'b1 << c)) begin n_errors++; $display("FAIL full_drain c=%0d got %b exp %b", c, bus.rsp_vld, 6'b1 << c); end
      tick();
    end
    bus.glb_dat_vld = 1'b0;
    #1;
    n_checks++; if ({busy, err} !== 2'b00) begin n_errors++; $display("FAIL full_idle got %b exp 00", {busy, err}); end
  endtask

  // Core 3 then core 1; core 3 back-pressures its data for 3 cycles.
  task automatic test_back_to_back();
    do_clr();
    d0 = {16{32'hDEAD_0000}};
    d1 = {16{32'h0000_BEEF}};
    bus.glb_addr_rdy = 1'b1;
    bus.req_addr[3*IW +: IW] = 10'h010;
    bus.req_addr[1*IW +: IW] = 10'h020;
    bus.req_vld = 6'b001000;
    #1;
    n_checks++; if ({bus.req_rdy, bus.glb_addr} !== {6'b001000, 10'h010}) begin n_errors++; $display("FAIL b2b_issue3 got %b/%h exp 001000/010", bus.req_rdy, bus.glb_addr); end
    tick();
    bus.req_vld = 6'b000010;
    #1;
    n_checks++; if ({bus.req_rdy, bus.glb_addr} !== {6'b000010, 10'h020}) begin n_errors++; $display("FAIL b2b_issue1 got %b/%h exp 000010/020", bus.req_rdy, bus.glb_addr); end
    tick();
    bus.req_vld = '0;
    bus.glb_dat = d0;
    bus.glb_dat_vld = 1'b1;
    bus.rsp_rdy = 6'b110111;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if ({bus.glb_dat_rdy, bus.rsp_vld} !== 7'b0_001000) begin n_errors++; $display("FAIL b2b_hold c=%0d got %b exp 0001000", c, {bus.glb_dat_rdy, bus.rsp_vld}); end
      n_checks++; if (bus.rsp_dat !== d0) begin n_errors++; $display("FAIL b2b_hold_dat c=%0d got %h exp %h", c, bus.rsp_dat[31:0], d0[31:0]); end
      tick();
    end
    bus.rsp_rdy = 6'b111111;
    #1;
    n_checks++; if (bus.glb_dat_rdy !== 1'b1) begin n_errors++; $display("FAIL b2b_d0_rdy got %b exp 1", bus.glb_dat_rdy); end
    tick();
    bus.glb_dat = d1;
    #1;
    n_checks++; if ({bus.glb_dat_rdy, bus.rsp_vld} !== 7'b1_000010) begin n_errors++; $display("FAIL b2b_d1 got %b exp 1000010", {bus.glb_dat_rdy, bus.rsp_vld}); end
    n_checks++; if (bus.rsp_dat !== d1) begin n_errors++; $display("FAIL b2b_d1_dat got %h exp %h", bus.rsp_dat[31:0], d1[31:0]); end
    tick();
    bus.glb_dat_vld = 1'b0;
    #1;
    n_checks++; if ({busy, err} !== 2'b00) begin n_errors++; $display("FAIL b2b_idle got %b exp 00", {busy, err}); end
    idle_inputs();
  endtask

  // GLB not ready for 5 cycles: grant stays on core 1 and the stall counter reaches 5.
  task automatic test_stall();
    do_clr();
    bus.req_vld = 6'b001010;
    bus.glb_addr_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if ({bus.glb_addr_vld, bus.req_rdy, bus.glb_addr} !== {1'b1, 6'b0, 10'h101}) begin n_errors++; $display("FAIL stall_hold c=%0d got %b/%b/%h exp 1/000000/101", c, bus.glb_addr_vld, bus.req_rdy, bus.glb_addr); end
      tick();
    end
`ifdef POL_RD_ARB_PERF_EN
    n_checks++; if (perf_stall_cnt !== 32'd5) begin n_errors++; $display("FAIL perf_cnt got %0d exp 5", perf_stall_cnt); end
`endif
    bus.glb_addr_rdy = 1'b1;
    #1;
    n_checks++; if (bus.req_rdy !== 6'b000010) begin n_errors++; $display("FAIL stall_release got %b exp 000010", bus.req_rdy); end
    tick();
    bus.req_vld = '0;
  endtask

  // Data with no outstanding read sets a sticky err, cleared by clr along with rr_ptr.
  task automatic test_err();
    do_clr();
    bus.rsp_rdy = 6'b111111;
    bus.glb_dat_vld = 1'b1;
    #1;
    n_checks++; if ({bus.glb_dat_rdy, bus.rsp_vld} !== 7'b0) begin n_errors++; $display("FAIL err_norsp got %b exp 0", {bus.glb_dat_rdy, bus.rsp_vld}); end
    tick();
    bus.glb_dat_vld = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL err_set got %b exp 1", err); end
    tick();
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL err_sticky got %b exp 1", err); end
    do_clr();
    #1;
    n_checks++; if ({err, busy} !== 2'b00) begin n_errors++; $display("FAIL err_clr got %b exp 00", {err, busy}); end
    bus.req_vld = 6'b111111;
    #1;
    n_checks++; if (bus.req_rdy !== 6'b000001) begin n_errors++; $display("FAIL err_clr_ptr got %b exp 000001", bus.req_rdy); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_rr_all();
    test_rr_skip();
    test_full();
    test_back_to_back();
    test_stall();
    test_err();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
